// File: rtl/axi4lite_addr_decoder.sv
// axi4lite_addr_decoder: 1-master to 2-slave AXI4-lite address decoder/demux with internal DECERR target (optional error log: ADDR_DECODER_ERRLOG_EN)
module axi4lite_addr_decoder #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] S0_BASE = 32'h8000_0000,
  parameter logic [ADDR_W-1:0] S0_MASK = 32'hF800_0000,
  parameter logic [ADDR_W-1:0] S1_BASE = 32'hA000_0000,
  parameter logic [ADDR_W-1:0] S1_MASK = 32'hFFFF_F000
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [ADDR_W-1:0]     m_araddr,
  input  logic                  m_arvalid,
  output logic                  m_arready,
  output logic                  m_rvalid,
  input  logic                  m_rready,
  output logic [DATA_W-1:0]     m_rdata,
  output logic [1:0]            m_rresp,
  input  logic [ADDR_W-1:0]     m_awaddr,
  input  logic                  m_awvalid,
  output logic                  m_awready,
  input  logic [DATA_W-1:0]     m_wdata,
  input  logic [DATA_W/8-1:0]   m_wstrb,
  input  logic                  m_wvalid,
  output logic                  m_wready,
  output logic                  m_bvalid,
  input  logic                  m_bready,
  output logic [1:0]            m_bresp,
  output logic [ADDR_W-1:0]     s0_araddr,
  output logic                  s0_arvalid,
  input  logic                  s0_arready,
  input  logic                  s0_rvalid,
  output logic                  s0_rready,
  input  logic [DATA_W-1:0]     s0_rdata,
  input  logic [1:0]            s0_rresp,
  output logic [ADDR_W-1:0]     s0_awaddr,
  output logic                  s0_awvalid,
  input  logic                  s0_awready,
  output logic [DATA_W-1:0]     s0_wdata,
  output logic [DATA_W/8-1:0]   s0_wstrb,
  output logic                  s0_wvalid,
  input  logic                  s0_wready,
  input  logic                  s0_bvalid,
  output logic                  s0_bready,
  input  logic [1:0]            s0_bresp,
  output logic [ADDR_W-1:0]     s1_araddr,
  output logic                  s1_arvalid,
  input  logic                  s1_arready,
  input  logic                  s1_rvalid,
  output logic                  s1_rready,
  input  logic [DATA_W-1:0]     s1_rdata,
  input  logic [1:0]            s1_rresp,
  output logic [ADDR_W-1:0]     s1_awaddr,
  output logic                  s1_awvalid,
  input  logic                  s1_awready,
  output logic [DATA_W-1:0]     s1_wdata,
  output logic [DATA_W/8-1:0]   s1_wstrb,
  output logic                  s1_wvalid,
  input  logic                  s1_wready,
  input  logic                  s1_bvalid,
  output logic                  s1_bready,
  input  logic [1:0]            s1_bresp
`ifdef ADDR_DECODER_ERRLOG_EN
  ,
  input  logic                  err_clr,
  output logic                  err_valid,
  output logic [ADDR_W-1:0]     err_addr,
  output logic                  err_is_write
`endif
);
  typedef enum logic [1:0] {R_IDLE = 2'b01, R_DATA = 2'b10} r_state_t;
  typedef enum logic [2:0] {W_IDLE = 3'b001, W_DATA = 3'b010, W_RESP = 3'b100} w_state_t;
  typedef enum logic [1:0] {SEL_S0 = 2'd0, SEL_S1 = 2'd1, SEL_ERR = 2'd2} sel_t;

  r_state_t r_st, r_nxt;
  w_state_t w_st, w_nxt;
  sel_t     r_sel, w_sel, ar_sel, aw_sel;

  function automatic sel_t dec(input logic [ADDR_W-1:0] a);
    return ((a & S0_MASK) == S0_BASE) ? SEL_S0 : ((a & S1_MASK) == S1_BASE) ? SEL_S1 : SEL_ERR;
  endfunction

  assign ar_sel    = dec(m_araddr);
  assign aw_sel    = dec(m_awaddr);
  assign s0_araddr = m_araddr;
  assign s1_araddr = m_araddr;
  assign s0_awaddr = m_awaddr;
  assign s1_awaddr = m_awaddr;
  assign s0_wdata  = m_wdata;
  assign s1_wdata  = m_wdata;
  assign s0_wstrb  = m_wstrb;
  assign s1_wstrb  = m_wstrb;

  // State registers; the target select is captured on each address handshake
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_st  <= R_IDLE;
      w_st  <= W_IDLE;
      r_sel <= SEL_S0;
      w_sel <= SEL_S0;
    end else begin
      r_st  <= r_nxt;
      w_st  <= w_nxt;
      if (m_arready) r_sel <= ar_sel;
      if (m_awready) w_sel <= aw_sel;
    end
  end

  // Read path: ready is qualified by valid so an idle master never sees a spurious ERR-target ready
  always_comb begin
    r_nxt      = R_IDLE;
    m_arready  = 1'b0;
    m_rvalid   = 1'b0;
    m_rdata    = '0;
    m_rresp    = 2'b00;
    s0_arvalid = 1'b0;
    s1_arvalid = 1'b0;
    s0_rready  = 1'b0;
    s1_rready  = 1'b0;
    case (r_st)
      R_IDLE: begin
        s0_arvalid = m_arvalid & (ar_sel == SEL_S0);
        s1_arvalid = m_arvalid & (ar_sel == SEL_S1);
        m_arready  = m_arvalid & (ar_sel == SEL_S0 ? s0_arready : ar_sel == SEL_S1 ? s1_arready : 1'b1);
        r_nxt      = m_arready ? R_DATA : R_IDLE;
      end
      R_DATA: begin
        m_rvalid  = r_sel == SEL_S0 ? s0_rvalid : r_sel == SEL_S1 ? s1_rvalid : 1'b1;
        m_rdata   = r_sel == SEL_S0 ? s0_rdata : r_sel == SEL_S1 ? s1_rdata : '0;
        m_rresp   = r_sel == SEL_S0 ? s0_rresp : r_sel == SEL_S1 ? s1_rresp : 2'b11;
        s0_rready = m_rready & (r_sel == SEL_S0);
        s1_rready = m_rready & (r_sel == SEL_S1);
        r_nxt     = (m_rvalid & m_rready) ? R_IDLE : R_DATA;
      end
      default: r_nxt = R_IDLE;
    endcase
  end

  // Write path: AW, then W, then B, one transaction at a time
  always_comb begin
    w_nxt      = W_IDLE;
    m_awready  = 1'b0;
    m_wready   = 1'b0;
    m_bvalid   = 1'b0;
    m_bresp    = 2'b00;
    s0_awvalid = 1'b0;
    s1_awvalid = 1'b0;
    s0_wvalid  = 1'b0;
    s1_wvalid  = 1'b0;
    s0_bready  = 1'b0;
    s1_bready  = 1'b0;
    case (w_st)
      W_IDLE: begin
        s0_awvalid = m_awvalid & (aw_sel == SEL_S0);
        s1_awvalid = m_awvalid & (aw_sel == SEL_S1);
        m_awready  = m_awvalid & (aw_sel == SEL_S0 ? s0_awready : aw_sel == SEL_S1 ? s1_awready : 1'b1);
        w_nxt      = m_awready ? W_DATA : W_IDLE;
      end
      W_DATA: begin
        s0_wvalid = m_wvalid & (w_sel == SEL_S0);
        s1_wvalid = m_wvalid & (w_sel == SEL_S1);
        m_wready  = m_wvalid & (w_sel == SEL_S0 ? s0_wready : w_sel == SEL_S1 ? s1_wready : 1'b1);
        w_nxt     = m_wready ? W_RESP : W_DATA;
      end
      W_RESP: begin
        m_bvalid  = w_sel == SEL_S0 ? s0_bvalid : w_sel == SEL_S1 ? s1_bvalid : 1'b1;
        m_bresp   = w_sel == SEL_S0 ? s0_bresp : w_sel == SEL_S1 ? s1_bresp : 2'b11;
        s0_bready = m_bready & (w_sel == SEL_S0);
        s1_bready = m_bready & (w_sel == SEL_S1);
        w_nxt     = (m_bvalid & m_bready) ? W_IDLE : W_RESP;
      end
      default: w_nxt = W_IDLE;
    endcase
  end

`ifdef ADDR_DECODER_ERRLOG_EN
  logic ar_err, aw_err;
  assign ar_err = m_arready & (ar_sel == SEL_ERR);
  assign aw_err = m_awready & (aw_sel == SEL_ERR);

  // Sticky first-error log; a write wins over a simultaneous read, a new error wins over clear
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      err_valid    <= 1'b0;
      err_addr     <= '0;
      err_is_write <= 1'b0;
    end else if ((ar_err | aw_err) & (~err_valid | err_clr)) begin
      err_valid    <= 1'b1;
      err_addr     <= aw_err ? m_awaddr : m_araddr;
      err_is_write <= aw_err;
    end else if (err_clr) begin
      err_valid    <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_axi4lite_addr_decoder.sv
// tb_axi4lite_addr_decoder: directed self-checking bench for axi4lite_addr_decoder
module tb_axi4lite_addr_decoder;
  logic        CLK = 1'b0, RST_N;
  logic [31:0] m_araddr, m_awaddr, m_wdata, m_rdata;
  logic        m_arvalid, m_arready, m_rvalid, m_rready, m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_rresp, m_bresp;
  logic [31:0] s0_araddr, s0_awaddr, s0_wdata, s0_rdata, s1_araddr, s1_awaddr, s1_wdata, s1_rdata;
  logic [3:0]  s0_wstrb, s1_wstrb;
  logic        s0_arvalid, s0_arready, s0_rvalid, s0_rready, s0_awvalid, s0_awready, s0_wvalid, s0_wready, s0_bvalid, s0_bready;
  logic        s1_arvalid, s1_arready, s1_rvalid, s1_rready, s1_awvalid, s1_awready, s1_wvalid, s1_wready, s1_bvalid, s1_bready;
  logic [1:0]  s0_rresp, s0_bresp, s1_rresp, s1_bresp;
`ifdef ADDR_DECODER_ERRLOG_EN
  logic        err_clr, err_valid, err_is_write;
  logic [31:0] err_addr;
`endif
  int n_chk = 0, n_err = 0;

  always #5 CLK = ~CLK;

  axi4lite_addr_decoder dut (
    .CLK(CLK), .RST_N(RST_N),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready), .m_bvalid(m_bvalid),
    .m_bready(m_bready), .m_bresp(m_bresp),
    .s0_araddr(s0_araddr), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_awaddr(s0_awaddr), .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
    .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wvalid(s0_wvalid), .s0_wready(s0_wready), .s0_bvalid(s0_bvalid),
    .s0_bready(s0_bready), .s0_bresp(s0_bresp),
    .s1_araddr(s1_araddr), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_awaddr(s1_awaddr), .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
    .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wvalid(s1_wvalid), .s1_wready(s1_wready), .s1_bvalid(s1_bvalid),
    .s1_bready(s1_bready), .s1_bresp(s1_bresp)
`ifdef ADDR_DECODER_ERRLOG_EN
    , .err_clr(err_clr), .err_valid(err_valid), .err_addr(err_addr), .err_is_write(err_is_write)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    RST_N = 0;
    m_araddr = 0; m_arvalid = 0; m_rready = 0; m_awaddr = 0; m_awvalid = 0;
    m_wdata = 0; m_wstrb = 0; m_wvalid = 0; m_bready = 0;
    s0_arready = 0; s0_rvalid = 0; s0_rdata = 0; s0_rresp = 0; s0_awready = 0; s0_wready = 0; s0_bvalid = 0; s0_bresp = 0;
    s1_arready = 0; s1_rvalid = 0; s1_rdata = 0; s1_rresp = 0; s1_awready = 0; s1_wready = 0; s1_bvalid = 0; s1_bresp = 0;
`ifdef ADDR_DECODER_ERRLOG_EN
    err_clr = 0;
`endif
    step(); step();
    chk("rst_m_handshakes", {m_arready, m_awready, m_wready, m_rvalid, m_bvalid}, 0);
    chk("rst_m_rdata", m_rdata, 0);
    chk("rst_m_resp", {m_rresp, m_bresp}, 0);
    chk("rst_s_handshakes", {s0_arvalid, s0_rready, s0_awvalid, s0_wvalid, s0_bready,
                             s1_arvalid, s1_rready, s1_awvalid, s1_wvalid, s1_bready}, 0);
    RST_N = 1;
    step();

    // S0 read with two wait cycles on arready
    m_araddr = 32'h8000_0010; m_arvalid = 1;
    settle();
    chk("rd0_s0_arvalid", s0_arvalid, 1);
    chk("rd0_s1_arvalid", s1_arvalid, 0);
    chk("rd0_arready_wait", m_arready, 0);
    step();
    chk("rd0_arready_wait2", m_arready, 0);
    step();
    s0_arready = 1;
    settle();
    chk("rd0_arready", m_arready, 1);
    step();
    m_arvalid = 0; s0_arready = 0; m_rready = 1;
    settle();
    chk("rd0_rvalid_wait", m_rvalid, 0);
    chk("rd0_s0_rready", s0_rready, 1);
    chk("rd0_s1_rready", s1_rready, 0);
    chk("rd0_no_arready", m_arready, 0);
    step();
    s0_rvalid = 1; s0_rdata = 32'hDEAD_BEEF; s0_rresp = 2'b00;
    settle();
    chk("rd0_rvalid", m_rvalid, 1);
    chk("rd0_rdata", m_rdata, 32'hDEAD_BEEF);
    chk("rd0_rresp", m_rresp, 2'b00);
    chk("rd0_s1_arvalid_end", s1_arvalid, 0);
    step();
    s0_rvalid = 0; m_rready = 0;
    settle();
    chk("rd0_back_idle", m_rvalid, 0);

    // S1 write, W presented three cycles before AW
    m_wvalid = 1; m_wdata = 32'h41; m_wstrb = 4'b0001; s1_wready = 1; s1_awready = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("wr1_w_held", {m_wready, s1_wvalid}, 0);
      step();
    end
    m_awaddr = 32'hA000_0004; m_awvalid = 1;
    settle();
    chk("wr1_awready", m_awready, 1);
    chk("wr1_s1_awvalid", s1_awvalid, 1);
    chk("wr1_s0_awvalid", s0_awvalid, 0);
    chk("wr1_wready_idle", m_wready, 0);
    step();
    m_awvalid = 0;
    settle();
    chk("wr1_wready", m_wready, 1);
    chk("wr1_s1_wvalid", s1_wvalid, 1);
    chk("wr1_s0_wvalid", s0_wvalid, 0);
    chk("wr1_s1_wdata", s1_wdata, 32'h41);
    chk("wr1_s1_wstrb", s1_wstrb, 4'b0001);
    step();
    m_wvalid = 0; m_bready = 1; s1_bvalid = 1; s1_bresp = 2'b01;
    settle();
    chk("wr1_bvalid", m_bvalid, 1);
    chk("wr1_bresp", m_bresp, 2'b01);
    chk("wr1_s1_bready", s1_bready, 1);
    chk("wr1_s0_bready", s0_bready, 0);
    step();
    s1_bvalid = 0; m_bready = 0; s1_wready = 0; s1_awready = 0;
    settle();
    chk("wr1_back_idle", m_bvalid, 0);

    // Unmapped read gets internal DECERR, held while rready is low
    s0_rdata = 32'hDEAD_BEEF; s1_rdata = 32'hCAFE_F00D;
    m_araddr = 32'h0000_0000; m_arvalid = 1;
    settle();
    chk("err_rd_arready", m_arready, 1);
    chk("err_rd_no_slave", {s0_arvalid, s1_arvalid}, 0);
    step();
    m_arvalid = 0;
    settle();
    chk("err_rd_rvalid", m_rvalid, 1);
    chk("err_rd_rresp", m_rresp, 2'b11);
    chk("err_rd_rdata", m_rdata, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("err_rd_rvalid_hold", m_rvalid, 1);
    end
    m_rready = 1;
    settle();
    chk("err_rd_s_rready", {s0_rready, s1_rready}, 0);
    step();
    m_rready = 0;
    settle();
    chk("err_rd_done", m_rvalid, 0);

    // Concurrent S0 read and S1 write; second AW refused until B completes
    m_araddr = 32'h8000_0020; m_arvalid = 1; s0_arready = 1;
    m_awaddr = 32'hA000_0010; m_awvalid = 1; s1_awready = 1;
    m_wvalid = 1; m_wdata = 32'h55; m_wstrb = 4'hF; s1_wready = 1;
    settle();
    chk("cc_arready", m_arready, 1);
    chk("cc_awready", m_awready, 1);
    step();
    m_arvalid = 0; s0_arready = 0; m_awaddr = 32'hA000_0020;
    s0_rvalid = 1; s0_rdata = 32'h1234_5678; m_rready = 1;
    settle();
    chk("cc_aw2_refused_wdata", m_awready, 0);
    chk("cc_aw2_no_s1", s1_awvalid, 0);
    chk("cc_wready", m_wready, 1);
    chk("cc_rdata", m_rdata, 32'h1234_5678);
    chk("cc_rvalid", m_rvalid, 1);
    step();
    s0_rvalid = 0; m_rready = 0; m_wvalid = 0;
    settle();
    chk("cc_aw2_refused_resp", m_awready, 0);
    chk("cc_rd_done", m_rvalid, 0);
    s1_bvalid = 1; s1_bresp = 2'b00; m_bready = 1;
    settle();
    chk("cc_bvalid", m_bvalid, 1);
    step();
    s1_bvalid = 0; m_bready = 0;
    settle();
    chk("cc_aw2_accepted", m_awready, 1);
    m_awvalid = 0; s1_awready = 0; s1_wready = 0;
    step();
    step();

    // Reset while waiting for S0 read data abandons the transaction
    m_araddr = 32'h8000_0000; m_arvalid = 1; s0_arready = 1;
    step();
    m_arvalid = 0; s0_arready = 0;
    settle();
    chk("rst_mid_pre_rvalid", m_rvalid, 0);
    RST_N = 0;
    step();
    chk("rst_mid_m_handshakes", {m_arready, m_awready, m_wready, m_rvalid, m_bvalid}, 0);
    chk("rst_mid_s_handshakes", {s0_arvalid, s0_rready, s1_arvalid, s1_rready}, 0);
    RST_N = 1;
    s0_rvalid = 1; s0_rdata = 32'hBAD0_BAD0; m_rready = 1;
    settle();
    chk("rst_mid_late_rvalid", m_rvalid, 0);
    chk("rst_mid_late_rdata", m_rdata, 0);
    chk("rst_mid_late_rready", s0_rready, 0);
    step();
    s0_rvalid = 0; m_rready = 0;
    step();

`ifdef ADDR_DECODER_ERRLOG_EN
    // Error log: unmapped write captured, later unmapped read ignored, clear drops valid
    chk("log_reset", {err_valid, err_is_write}, 0);
    m_awaddr = 32'h1234_5678; m_awvalid = 1;
    settle();
    chk("log_aw_ready", m_awready, 1);
    step();
    m_awvalid = 0; m_wvalid = 1;
    settle();
    chk("log_w_ready", m_wready, 1);
    step();
    m_wvalid = 0; m_bready = 1;
    settle();
    chk("log_bresp", {m_bvalid, m_bresp}, 3'b111);
    step();
    m_bready = 0;
    m_araddr = 32'h0; m_arvalid = 1;
    step();
    m_arvalid = 0; m_rready = 1;
    step();
    m_rready = 0;
    settle();
    chk("log_valid", err_valid, 1);
    chk("log_addr", err_addr, 32'h1234_5678);
    chk("log_is_write", err_is_write, 1);
    err_clr = 1;
    step();
    err_clr = 0;
    settle();
    chk("log_cleared", err_valid, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/axi4lite_addr_decoder.md
Name: axi4lite_addr_decoder

Overview:
- 1-master to 2-slave AXI4-lite address decoder and demux. It is the fan-out counterpart to the 2:1 round-robin arbiter.
- Sits between the arbitrated master port and two memory-mapped slaves: S0 is SRAM and S1 is the peripheral/UART window.
- Routes each read and write transaction to the slave selected by address. Unmapped addresses get an internal DECERR response.
- At most one outstanding read and one outstanding write. Read and write paths are independent.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- S0_BASE, 32'h8000_0000, S0 base address.
- S0_MASK, 32'hF800_0000, S0 match mask: hit when (addr & S0_MASK) == S0_BASE.
- S1_BASE, 32'hA000_0000, S1 base address.
- S1_MASK, 32'hFFFF_F000, S1 match mask.

Ports:
- CLK  input  1  clock, all logic on the rising edge.
- RST_N  input  1  synchronous reset, active-low.
- m_araddr, m_awaddr  input  ADDR_W  master read and write addresses.
- m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready  input  1  master-side handshakes.
- m_arready, m_awready, m_wready, m_rvalid, m_bvalid  output  1  master-side handshakes.
- m_wdata  input  DATA_W  write data.
- m_wstrb  input  DATA_W/8  write strobes.
- m_rdata  output  DATA_W  read data.
- m_rresp, m_bresp  output  2  response codes.
- sN_araddr, sN_awaddr  output  ADDR_W  address to slave N (N=0,1).
- sN_wdata  output  DATA_W  write data to slave N.
- sN_wstrb  output  DATA_W/8  write strobes to slave N.
- sN_arvalid, sN_awvalid, sN_wvalid, sN_rready, sN_bready  output  1  handshakes to slave N.
- sN_arready, sN_awready, sN_wready, sN_rvalid, sN_bvalid  input  1  handshakes from slave N.
- sN_rdata  input  DATA_W  read data from slave N.
- sN_rresp, sN_bresp  input  2  response codes from slave N.

Behaviour:
- Decode is combinational on the current address.
  - S0 hit takes priority over S1 hit.
  - No hit selects the internal error target ERR.
- The selected target is latched into a register on the address handshake. Later phases use only this latched select.
- Read FSM, one-hot: R_IDLE=2'b01, R_DATA=2'b10.
  - R_IDLE: m_arvalid drives only the decoded slave's sN_arvalid; m_arready = that slave's arready.
  - R_IDLE with ERR: m_arready=1.
  - R_IDLE -> R_DATA on m_arvalid & m_arready, latching the select.
  - R_DATA: m_arready=0; forward the selected slave's rvalid, rdata and rresp; sN_rready = m_rready for the selected slave only.
  - R_DATA with ERR: m_rvalid=1, m_rdata=0, m_rresp=2'b11.
  - R_DATA -> R_IDLE on m_rvalid & m_rready.
- Write FSM, one-hot: W_IDLE=3'b001, W_DATA=3'b010, W_RESP=3'b100.
  - W_IDLE: route AW the same way as AR; m_wready=0.
  - W_IDLE -> W_DATA on the AW handshake, latching the select.
  - W_DATA: route W to the latched target, with wdata and wstrb passed through. ERR accepts with wready=1.
  - W_DATA -> W_RESP on the W handshake.
  - W_RESP: route B from the latched target. ERR returns bvalid=1, bresp=2'b11.
  - W_RESP -> W_IDLE on m_bvalid & m_bready.
- W before AW: W is held off (m_wready=0) until the AW handshake completes.
- Only one write is accepted at a time: AW is refused (m_awready=0) in W_DATA and W_RESP.
- Non-selected slaves always see valid=0 and ready=0.
- Address and data buses are broadcast to both slaves; only valid/ready are gated.
- Latency: zero added cycles; all paths are combinational pass-through gated by state. The ERR response appears the cycle after the address handshake.
- Simultaneous read and write to the same or different slaves proceed independently. Slave ordering is the slave's concern.
- Invalid FSM encodings return to IDLE on the next cycle.
- Reset (RST_N=0 at a clock edge):
  - Both FSMs go to IDLE and the select registers clear to S0.
  - All master-side outputs are 0: valid/ready signals, m_rdata, m_rresp, m_bresp.
  - All slave valid/ready outputs are 0.
- Reset mid-transaction abandons it. Responses from a slave after reset are not forwarded, because the FSM is in IDLE.

Optional Feature:
- Macro: ADDR_DECODER_ERRLOG_EN.
- When defined:
  - Adds ports err_clr (input, 1), err_valid (output, 1), err_addr (output, ADDR_W) and err_is_write (output, 1).
  - On the first ERR-target address handshake while err_valid=0: capture the address, set err_is_write (1 for AW, 0 for AR), and set err_valid sticky.
  - If a simultaneous AR and AW both hit ERR, the write is captured.
  - Subsequent errors are ignored until err_clr=1 clears err_valid on the next edge.
  - If err_clr and a new error land on the same cycle, the new error is captured.
  - Reset clears all three outputs.
- When undefined: none of these ports or registers exist.

Test Plan:
- Read 0x8000_0010, S0 rdata=0xDEADBEEF with 2 wait cycles -> m_rdata=0xDEADBEEF, m_rresp=00; s1_arvalid stays 0 throughout.
- Write 0xA000_0004 with data 0x41, strobe 4'b0001, W presented 3 cycles before AW -> m_wready=0 until the AW handshake; s1 sees data 0x41; m_bresp = s1_bresp.
- Read 0x0000_0000 (unmapped) -> m_arready=1 immediately; next cycle m_rvalid=1, m_rresp=11, m_rdata=0; m_rready held low 4 cycles keeps rvalid asserted.
- Concurrent read of S0 and write of S1 in the same cycle -> both complete independently; second AW refused until B handshake done.
- RST_N=0 asserted while in R_DATA waiting on S0 -> next cycle all valid/ready outputs 0, FSM in R_IDLE; a late s0_rvalid does not reach m_rvalid.
- (ERRLOG) Unmapped write to 0x1234_5678, then unmapped read to 0x0 -> err_addr=0x1234_5678, err_is_write=1; err_clr pulse -> err_valid=0.
